// File: rtl/lamp_fpu_exp_mul_rnd.sv
// bfloat16 multiplier rounding/packing stage: RNE rounding, exponent carry, overflow-to-Inf,
// small output FIFO with valid/ready and sticky {OVF,UNF,INEXACT,DROP} flags. Option: LAMP_FPU_RND_FTZ_EN.
module lamp_fpu_exp_mul_rnd #(
    parameter int unsigned E_DW       = 8,
    parameter int unsigned F_DW       = 7,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 s_i,
    input  logic [E_DW-1:0]      e_i,
    input  logic [F_DW+4:0]      f_i,
    input  logic                 isOverflow_i,
    input  logic                 isUnderflow_i,
    input  logic                 isToRound_i,
    input  logic                 ready_i,
    input  logic                 clr_flags_i,
    output logic [E_DW+F_DW:0]   res_o,
    output logic                 valid_o,
    output logic [3:0]           flags_o
);

    localparam int unsigned RW = 1 + E_DW + F_DW;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [F_DW:0]   mant;
    logic            lsb, g, rs, inexact, rup;
    logic [F_DW+1:0] sum;
    logic [E_DW-1:0] e_inc;
    logic [E_DW-1:0] rnd_e;
    logic [F_DW-1:0] rnd_f;
    logic            ovf_ev, unf_ev, inx_ev;

    // The overflow bit of f_i is already folded into isOverflow_i upstream.
    logic unused_ovf_bit;
    assign unused_ovf_bit = f_i[F_DW+4];

    // Round-to-nearest-even and result packing
    always_comb begin
        mant    = f_i[F_DW+3:3];
        lsb     = f_i[3];
        g       = f_i[2];
        rs      = f_i[1] | f_i[0];
        inexact = g | rs;
        rup     = g & (rs | lsb);
        sum     = (F_DW+2)'(mant) + (F_DW+2)'(rup);
        e_inc   = e_i + E_DW'(1);
        rnd_e   = e_i;
        rnd_f   = sum[F_DW-1:0];
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        inx_ev  = 1'b0;
        if (!isToRound_i) begin
            rnd_f = f_i[F_DW+2:3];
        end else if (isOverflow_i) begin
            rnd_e  = '1;
            rnd_f  = '0;
            ovf_ev = 1'b1;
            inx_ev = 1'b1;
        end else begin
            inx_ev = inexact;
            unf_ev = isUnderflow_i & inexact;
            if (sum[F_DW+1]) begin
                rnd_f = '0;
                if (e_inc == '1) begin
                    rnd_e  = '1;
                    ovf_ev = 1'b1;
                end else begin
                    rnd_e = e_inc;
                end
            end else if ((e_i == '0) && sum[F_DW]) begin
                rnd_e = E_DW'(1);
            end
`ifdef LAMP_FPU_RND_FTZ_EN
            if ((rnd_e == '0) && (rnd_f != '0)) begin
                rnd_f  = '0;
                unf_ev = 1'b1;
                inx_ev = 1'b1;
            end
`endif
        end
    end

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    flags_q, flags_d;
    logic          full, pop, push, drop;

    // FIFO control and sticky flag next state
    always_comb begin
        full     = (cnt_q == CW'(FIFO_DEPTH));
        pop      = valid_q & ready_i;
        push     = valid_i & (~full | pop);
        drop     = valid_i & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        valid_d = (cnt_d != '0);
        flags_d = clr_flags_i ? 4'b0000 : flags_q;
        if (valid_i) begin
            flags_d = flags_d | {ovf_ev, unf_ev, inx_ev, drop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {s_i, rnd_e, rnd_f};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            flags_q  <= flags_d;
        end
    end

    assign res_o   = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign flags_o = flags_q;

endmodule

// File: tb/tb_lamp_fpu_exp_mul_rnd.sv
// Bench for lamp_fpu_exp_mul_rnd: arithmetic rounding model + queue scoreboard, plus literal checks.
module tb_lamp_fpu_exp_mul_rnd;

    logic        clk = 1'b0;
    logic        rst, valid_i, s_i, isOverflow_i, isUnderflow_i, isToRound_i, ready_i, clr_flags_i;
    logic [7:0]  e_i;
    logic [11:0] f_i;
    logic [15:0] res_o;
    logic        valid_o;
    logic [3:0]  flags_o;

    int n_cmp  = 0;
    int n_fail = 0;

    lamp_fpu_exp_mul_rnd dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .s_i(s_i), .e_i(e_i), .f_i(f_i),
        .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i), .isToRound_i(isToRound_i),
        .ready_i(ready_i), .clr_flags_i(clr_flags_i),
        .res_o(res_o), .valid_o(valid_o), .flags_o(flags_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value-level model: integer mantissa, remainder-based RNE, then repack.
    function automatic void model(input logic s, input logic [7:0] e, input logic [11:0] f,
                                  input logic ov, input logic un, input logic tr,
                                  output logic [15:0] r, output logic [2:0] fl);
        int m, rem, rr, ee, fr;
        bit inx, unf, ovf;
        if (!tr) begin
            r = {s, e, f[9:3]}; fl = 3'b000;
        end else if (ov) begin
            r = {s, 8'hFF, 7'h00}; fl = 3'b101;
        end else begin
            m   = int'(f[10:3]);
            rem = int'(f[2:0]);
            rr  = m + (((rem > 4) || (rem == 4 && (m % 2) == 1)) ? 1 : 0);
            inx = (rem != 0);
            ovf = 0;
            ee  = int'(e);
            if (rr >= 256) begin
                ee = ee + 1; rr = 0;
                if (ee >= 255) begin ee = 255; ovf = 1; end
            end else if (ee == 0 && rr >= 128) begin
                ee = 1;
            end
            fr  = rr % 128;
            unf = un && inx;
`ifdef LAMP_FPU_RND_FTZ_EN
            if (ee == 0 && fr != 0) begin fr = 0; unf = 1; inx = 1; end
`endif
            r  = {s, 8'(ee), 7'(fr)};
            fl = {ovf, unf, inx};
        end
    endfunction

    logic [15:0] q[$];
    logic [3:0]  mflags;

    // Scoreboard: 2-entry queue with push/pop/drop semantics and sticky flags.
    always @(posedge clk) begin
        logic [15:0] r;
        logic [2:0]  fl;
        bit          pop, drop;
        if (rst) begin
            q.delete();
            mflags = 4'b0000;
        end else begin
            model(s_i, e_i, f_i, isOverflow_i, isUnderflow_i, isToRound_i, r, fl);
            pop  = (q.size() != 0) && ready_i;
            drop = 0;
            if (pop) void'(q.pop_front());
            if (valid_i) begin
                if (q.size() < 2) q.push_back(r);
                else drop = 1;
            end
            if (clr_flags_i) mflags = 4'b0000;
            if (valid_i) mflags = mflags | {fl, drop};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("sb_valid", 16'(valid_o), 16'(q.size() != 0));
            chk("sb_flags", 16'(flags_o), 16'(mflags));
            if (q.size() != 0) chk("sb_res", res_o, q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [11:0] f,
                         input logic ov, input logic un, input logic tr, input logic clr);
        valid_i = 1'b1; s_i = s; e_i = e; f_i = f;
        isOverflow_i = ov; isUnderflow_i = un; isToRound_i = tr; clr_flags_i = clr;
        step();
        valid_i = 1'b0; clr_flags_i = 1'b0; isOverflow_i = 1'b0; isUnderflow_i = 1'b0;
    endtask

    logic [11:0] ftab [12] = '{12'h40C, 12'h404, 12'h414, 12'h7FC, 12'h7F4, 12'h403,
                               12'h40B, 12'h3FF, 12'h001, 12'h55D, 12'h6A6, 12'h500};
    logic [7:0]  etab [12] = '{8'h80, 8'h00, 8'h7F, 8'h10, 8'hFE, 8'h01,
                               8'h00, 8'h00, 8'h00, 8'hC3, 8'hFE, 8'h3A};

    initial begin
        rst = 1'b1; valid_i = 1'b0; s_i = 1'b0; e_i = '0; f_i = '0;
        isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b1;
        ready_i = 1'b1; clr_flags_i = 1'b0;
        step(); step();
        chk("rst_valid", 16'(valid_o), 16'h0000);
        chk("rst_flags", 16'(flags_o), 16'h0000);
        chk("rst_res", res_o, 16'h0000);
        rst = 1'b0;
        step();

        drive(1'b0, 8'h80, 12'h40C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tie_odd_res", res_o, 16'h4002);
        chk("tie_odd_flags", 16'(flags_o), 16'h0002);
        drive(1'b0, 8'h80, 12'h404, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tie_even_res", res_o, 16'h4000);
        chk("tie_even_inx", 16'(flags_o[1]), 16'h0001);
        drive(1'b0, 8'hFE, 12'h7FE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("carry_inf_res", res_o, 16'h7F80);
        chk("carry_inf_flags", 16'(flags_o), 16'h000A);
        drive(1'b0, 8'hFF, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pass_nan_res", res_o, 16'h7FC0);
        chk("pass_nan_flags", 16'(flags_o), 16'h000A);

        clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
        chk("clr_flags", 16'(flags_o), 16'h0000);
        drive(1'b1, 8'h90, 12'h400, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ovf_res", res_o, 16'hFF80);
        chk("clr_vs_ovf_flags", 16'(flags_o), 16'h000A);

        drive(1'b0, 8'h00, 12'h100, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef LAMP_FPU_RND_FTZ_EN
        chk("sub_ftz_res", res_o, 16'h0000);
        chk("sub_ftz_unf", 16'(flags_o[2]), 16'h0001);
`else
        chk("sub_res", res_o, 16'h0020);
        chk("sub_flags", 16'(flags_o), 16'h000A);
`endif
        drive(1'b0, 8'h00, 12'h3FC, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sub_to_norm_res", res_o, 16'h0080);
        chk("sub_to_norm_flags", 16'(flags_o), 16'h000E);
        step();

        clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 8'h80, 12'h400, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h81, 12'h400, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h82, 12'h400, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_valid", 16'(valid_o), 16'h0001);
        chk("full_head_A", res_o, 16'h4000);
        chk("full_drop", 16'(flags_o), 16'h0001);
        step();
        chk("stall_hold_A", res_o, 16'h4000);
        ready_i = 1'b1;
        step();
        chk("drain_B", res_o, 16'h4080);
        chk("drain_B_valid", 16'(valid_o), 16'h0001);
        step();
        chk("drain_empty", 16'(valid_o), 16'h0000);

        for (int i = 0; i < 12; i++) begin
            ready_i = (i % 3) != 1;
            drive(1'(i % 2), etab[i], ftab[i], 1'b0, 1'(i % 4 == 0), 1'b1, 1'(i == 6));
        end
        ready_i = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
